// File: rtl/alu_pkg.sv
// Shared types for the ALU execute stage: command encodings, internal ops,
// FSM states, the NZCV flag record and the command decoder.
package alu_pkg;

   typedef enum logic [3:0] {
      CMD_AND = 4'b0000,
      CMD_EOR = 4'b0001,
      CMD_SUB = 4'b0010,
      CMD_ADD = 4'b0100,
      CMD_ADC = 4'b0101,
      CMD_TST = 4'b1000,
      CMD_CMP = 4'b1010,
      CMD_CMN = 4'b1011,
      CMD_ORR = 4'b1100,
      CMD_SHF = 4'b1101
   } alu_cmd_e;

   typedef enum logic [2:0] {
      CTL_ADD, CTL_ADC, CTL_SUB, CTL_AND, CTL_ORR, CTL_EOR, CTL_SHIFT, CTL_ILLEGAL
   } alu_ctl_e;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } nzcv_t;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef struct packed {
      alu_ctl_e ctl;
      logic     no_write;
      logic     illegal;
      logic     wr_nz;
      logic     wr_cv;
   } dec_t;

   // Compares always write flags; arithmetic writes C/V only with s; logic ops never touch C/V.
   function automatic dec_t alu_decode(input logic alu_op, input logic s, input logic [3:0] cmd);
      dec_t d;
      d = '{ctl: CTL_ADD, no_write: 1'b0, illegal: 1'b0, wr_nz: 1'b0, wr_cv: 1'b0};
      if (alu_op) begin
         d.wr_nz = s;
         case (cmd)
            CMD_ADD: begin d.ctl = CTL_ADD; d.wr_cv = s; end
            CMD_SUB: begin d.ctl = CTL_SUB; d.wr_cv = s; end
            CMD_ADC: begin d.ctl = CTL_ADC; d.wr_cv = s; end
            CMD_AND: d.ctl = CTL_AND;
            CMD_ORR: d.ctl = CTL_ORR;
            CMD_EOR: d.ctl = CTL_EOR;
            CMD_SHF: d.ctl = CTL_SHIFT;
            CMD_CMP: begin d.ctl = CTL_SUB; d.no_write = 1'b1; d.wr_nz = 1'b1; d.wr_cv = 1'b1; end
            CMD_CMN: begin d.ctl = CTL_ADD; d.no_write = 1'b1; d.wr_nz = 1'b1; d.wr_cv = 1'b1; end
            CMD_TST: begin d.ctl = CTL_AND; d.no_write = 1'b1; d.wr_nz = 1'b1; end
            default: begin
               d.ctl      = CTL_ILLEGAL;
               d.no_write = 1'b1;
               d.illegal  = 1'b1;
               d.wr_nz    = 1'b0;
            end
         endcase
      end
      return d;
   endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational add/sub/logic datapath with NZCV generation for the ALU execute stage.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  alu_ctl_e           ctl_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   input  logic               carry_i,
   output logic [WIDTH-1:0]   result_o,
   output nzcv_t              nzcv_o
);

   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] b_op;
   logic             cin;

   // Subtract as a + ~b + 1 so the carry-out is directly NOT borrow.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      b_op = b_i;
      cin  = 1'b0;
      if (ctl_i == CTL_SUB) begin
         b_op = ~b_i;
         cin  = 1'b1;
      end else if (ctl_i == CTL_ADC) begin
         cin = carry_i;
      end
      sum = {1'b0, a_i} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};

      case (ctl_i)
         CTL_ADD, CTL_ADC, CTL_SUB: result_o = sum[WIDTH-1:0];
         CTL_AND:                   result_o = a_i & b_i;
         CTL_ORR:                   result_o = a_i | b_i;
         CTL_EOR:                   result_o = a_i ^ b_i;
         default:                   result_o = '0;
      endcase

      nzcv_o.n = result_o[WIDTH-1];
      nzcv_o.z = (result_o == '0);
      nzcv_o.c = sum[WIDTH];
      nzcv_o.v = (a_i[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
   end

endmodule

// File: rtl/alu_exec_unit.sv
// Handshaked ALU execute stage: FSM, shifter and NZCV flag register around alu_core.
// Define ALU_BARREL_SHIFT_EN for single-cycle barrel shifts; otherwise shifts step 1 bit/cycle.
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               alu_op,
   input  logic               s,
   input  logic [3:0]         cmd,
   input  logic               sh_right,
   input  logic [WIDTH-1:0]   src_a,
   input  logic [WIDTH-1:0]   src_b,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   result,
   output logic               no_write,
   output logic               illegal,
   output logic [3:0]         flags
);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic               dir_q, dir_d;
   logic               wr_nz_q, wr_nz_d;
   logic               no_write_q, no_write_d;
   logic               illegal_q, illegal_d;
   nzcv_t              flags_q, flags_d;

   dec_t               dec;
   logic               accept;
   logic [WIDTH-1:0]   core_result;
   nzcv_t              core_nzcv;
   logic [WIDTH-1:0]   shifted;

   function automatic nzcv_t set_nz(input nzcv_t f, input logic [WIDTH-1:0] r);
      nzcv_t o;
      o   = f;
      o.n = r[WIDTH-1];
      o.z = (r == '0);
      return o;
   endfunction

   assign dec      = alu_decode(alu_op, s, cmd);
   assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
   assign accept   = in_valid && in_ready;

   alu_core #(.WIDTH(WIDTH)) u_core (
      .ctl_i    (dec.ctl),
      .a_i      (src_a),
      .b_i      (src_b),
      .carry_i  (flags_q.c),
      .result_o (core_result),
      .nzcv_o   (core_nzcv)
   );

   // During SHIFT the result register doubles as the shift register.
   assign shifted = dir_q ? (result_q >> 1) : (result_q << 1);

   always_comb begin
      state_d    = state_q;
      result_d   = result_q;
      cnt_d      = cnt_q;
      dir_d      = dir_q;
      wr_nz_d    = wr_nz_q;
      no_write_d = no_write_q;
      illegal_d  = illegal_q;
      flags_d    = flags_q;

      case (state_q)
         SHIFT: begin
            result_d = shifted;
            cnt_d    = cnt_q - SHAMT_W'(1);
            if (cnt_q == SHAMT_W'(1)) begin
               state_d = DONE;
               if (wr_nz_q) flags_d = set_nz(flags_q, shifted);
            end
         end
         DONE:    if (out_ready) state_d = IDLE;
         default: ;
      endcase

      if (accept) begin
         no_write_d = dec.no_write;
         illegal_d  = dec.illegal;
         if (dec.ctl == CTL_SHIFT) begin
`ifdef ALU_BARREL_SHIFT_EN
            result_d = sh_right ? (src_b >> shamt) : (src_b << shamt);
            state_d  = DONE;
            if (dec.wr_nz) flags_d = set_nz(flags_q, result_d);
`else
            result_d = src_b;
            cnt_d    = shamt;
            dir_d    = sh_right;
            wr_nz_d  = dec.wr_nz;
            if (shamt == '0) begin
               state_d = DONE;
               if (dec.wr_nz) flags_d = set_nz(flags_q, src_b);
            end else begin
               state_d = SHIFT;
            end
`endif
         end else begin
            result_d = core_result;
            state_d  = DONE;
            if (dec.wr_nz) begin
               flags_d.n = core_nzcv.n;
               flags_d.z = core_nzcv.z;
            end
            if (dec.wr_cv) begin
               flags_d.c = core_nzcv.c;
               flags_d.v = core_nzcv.v;
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         result_q   <= '0;
         cnt_q      <= '0;
         dir_q      <= 1'b0;
         wr_nz_q    <= 1'b0;
         no_write_q <= 1'b0;
         illegal_q  <= 1'b0;
         flags_q    <= '0;
      end else begin
         state_q    <= state_d;
         result_q   <= result_d;
         cnt_q      <= cnt_d;
         dir_q      <= dir_d;
         wr_nz_q    <= wr_nz_d;
         no_write_q <= no_write_d;
         illegal_q  <= illegal_d;
         flags_q    <= flags_d;
      end
   end

   assign out_valid     = (state_q == DONE);
   assign result        = result_q;
   assign no_write      = no_write_q;
   assign illegal       = illegal_q;
   assign flags[FLAG_N] = flags_q.n;
   assign flags[FLAG_Z] = flags_q.z;
   assign flags[FLAG_C] = flags_q.c;
   assign flags[FLAG_V] = flags_q.v;

endmodule
